uart_rx_param: RTL

//  Parametrised UART receiver: serial rx -> parallel word with valid/ack handshake.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_param_if.sv | 22 ++
 rtl/uart_rx_sync.sv | 28 ++
 rtl/uart_rx_param.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding, default bit period and parity sense.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 5208;  // 50 MHz / 9600 baud
    localparam int PAR_EVEN             = 0;
    localparam int PAR_ODD              = 1;

endpackage

// File: rtl/uart_rx_param_if.sv
// Receiver-to-consumer bundle: received word, valid/ack handshake, error flags and activity LED.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 rx_valid;
    logic                 rd_ack;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun_err;
    logic                 led;

    modport master (
        output data, rx_valid, frame_err, parity_err, overrun_err, led,
        input  rd_ack
    );

    modport slave (
        input  data, rx_valid, frame_err, parity_err, overrun_err, led,
        output rd_ack
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the rx pin plus a delayed copy for falling-edge detection.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);
    logic ff1_reg;
    logic ff2_reg;
    logic prev_reg;

    // Everything resets to the idle-high level so a reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ff1_reg  <= 1'b1;
            ff2_reg  <= 1'b1;
            prev_reg <= 1'b1;
        end else begin
            ff1_reg  <= rx;
            ff2_reg  <= ff1_reg;
            prev_reg <= ff2_reg;
        end
    end

    assign rx_s = ff2_reg;
    assign fall = prev_reg & ~ff2_reg;
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with glitch rejection, framing/overrun checks and valid/ack output.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = PAR_EVEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    uart_rx_param_if.master  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);
    localparam logic          PAR_SENSE = 1'(PARITY_ODD);
    // An out-of-range configuration leaves the receiver permanently idle.
    localparam bit CFG_OK = (CLKS_PER_BIT >= 8) && (DATA_BITS >= 5) && (DATA_BITS <= 8) &&
                            (STOP_BITS >= 1) && (STOP_BITS <= 2) &&
                            (PARITY_ODD >= 0) && (PARITY_ODD <= 1);

    logic rx_s;
    logic fall;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s),
        .fall (fall)
    );

    uart_state_t          state_reg,    state_next;
    logic [CW-1:0]        cnt_reg,      cnt_next;
    logic [2:0]           bit_idx_reg,  bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg,    shift_next;
    logic                 stop_bit_reg, stop_bit_next;
    logic                 done_reg,     done_next;
    logic                 par_bad;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_reg,  par_bit_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            stop_bit_reg <= 1'b0;
            done_reg     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_reg  <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= shift_next;
            stop_bit_reg <= stop_bit_next;
            done_reg     <= done_next;
`ifdef UART_RX_PARITY_EN
            par_bit_reg  <= par_bit_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_idx_next  = bit_idx_reg;
        shift_next    = shift_reg;
        stop_bit_next = stop_bit_reg;
        done_next     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_next  = par_bit_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (fall && CFG_OK) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                // The start bit must stay low up to its midpoint, otherwise it was a glitch.
                if (rx_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_HALF) begin
                    state_next   = DATA;
                    cnt_next     = '0;
                    bit_idx_next = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DATA: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next               = '0;
                    shift_next[bit_idx_reg] = rx_s;
                    if (bit_idx_reg == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next     = '0;
                    par_bit_next = rx_s;
                    state_next   = STOP;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
`endif
            STOP: begin
                // Only the first stop bit is sampled; any further stop time is spent in IDLE.
                if (cnt_reg == CNT_LAST) begin
                    cnt_next      = '0;
                    stop_bit_next = rx_s;
                    done_next     = 1'b1;
                    state_next    = IDLE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign par_bad = par_bit_reg != ((^shift_reg) ^ PAR_SENSE);
`else
    assign par_bad = 1'b0;
`endif

    logic [DATA_BITS-1:0] data_reg;
    logic                 valid_reg;
    logic                 frame_err_reg;
    logic                 parity_err_reg;
    logic                 overrun_reg;
    logic                 led_reg;

    // A completing word always wins over a same-cycle ack: valid stays set and overrun is untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            led_reg        <= 1'b0;
        end else begin
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            if (done_reg) begin
                data_reg       <= shift_reg;
                valid_reg      <= 1'b1;
                frame_err_reg  <= ~stop_bit_reg;
                parity_err_reg <= par_bad;
                if (valid_reg && !bus.rd_ack)
                    overrun_reg <= 1'b1;
                if (stop_bit_reg && !par_bad)
                    led_reg <= ~led_reg;
            end else if (bus.rd_ack) begin
                overrun_reg <= 1'b0;
                if (valid_reg)
                    valid_reg <= 1'b0;
            end
        end
    end

    assign bus.data        = data_reg;
    assign bus.rx_valid    = valid_reg;
    assign bus.frame_err   = frame_err_reg;
    assign bus.parity_err  = parity_err_reg;
    assign bus.overrun_err = overrun_reg;
    assign bus.led         = led_reg;
endmodule
